// File: rtl/xcore_fifo_pkg.sv
// Shared helpers for the Xcore synchronous FIFO: log2 sizing and pointer/count width derivation.
package xcore_fifo_pkg;

    localparam int DEF_DW    = 8;
    localparam int DEF_DEPTH = 16;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    function automatic int ptr_w(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/xcore_fifo_ram.sv
// DEPTH x DW simple dual-port register array; XCORE_FIFO_FWFT_EN selects an asynchronous
// read port, otherwise the read port is registered with an enable.
module xcore_fifo_ram
    import xcore_fifo_pkg::*;
#(
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

`ifdef XCORE_FIFO_FWFT_EN
    assign rd_data = mem[rd_addr];
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end
`endif

endmodule

// File: rtl/xcore_sync_fifo.sv
// Single-clock FIFO with fill count, almost-full/almost-empty thresholds and error pulses.
// Defining XCORE_FIFO_FWFT_EN switches the read side to first-word-fall-through.
module xcore_sync_fifo
    import xcore_fifo_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          wr_en,
    input  logic [DW-1:0] din,
    output logic          full,
    output logic          almost_full,
    output logic          overflow,
    input  logic          rd_en,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic          empty,
    output logic          almost_empty,
    output logic          underflow,
    output logic [AW:0]   data_cnt
);

    localparam logic [AW:0] AF_CNT = (AW + 1)'(AF_LVL);
    localparam logic [AW:0] AE_CNT = (AW + 1)'(AE_LVL);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        wr_ok;
    logic        rd_ok;

    // Handshake: a write transfers when wr_en && !full, a read when rd_en && !empty; both
    // judged on the flags at the start of the cycle. Requests against the wrong flag are
    // dropped and reported one cycle later on overflow/underflow.
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    assign data_cnt     = wr_ptr - rd_ptr;
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign almost_full  = (data_cnt >= AF_CNT);
    assign almost_empty = (data_cnt <= AE_CNT);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
        end
    end

`ifdef XCORE_FIFO_FWFT_EN
    assign dout_vld = !empty;
`else
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) dout_vld <= 1'b0;
        else         dout_vld <= rd_ok;
    end
`endif

    xcore_fifo_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .wr_en   (wr_ok),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (din),
        .rd_en   (rd_ok),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (dout)
    );

endmodule

// File: tb/tb_xcore_sync_fifo.sv
// Directed bench for xcore_sync_fifo (DEPTH=16, DW=8) with a count/queue reference model;
// XCORE_FIFO_FWFT_EN selects the first-word-fall-through expectations.
module tb_xcore_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    // ---------------- clock / reset ----------------
    logic          sys_clk;
    logic          sys_rst;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          full;
    logic          almost_full;
    logic          overflow;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          dout_vld;
    logic          empty;
    logic          almost_empty;
    logic          underflow;
    logic [4:0]    data_cnt;

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    xcore_sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .wr_en        (wr_en),
        .din          (din),
        .full         (full),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .rd_en        (rd_en),
        .dout         (dout),
        .dout_vld     (dout_vld),
        .empty        (empty),
        .almost_empty (almost_empty),
        .underflow    (underflow),
        .data_cnt     (data_cnt)
    );

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int            mc;
    int            n_cmp;
    int            n_bad;
    logic [DW-1:0] last_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Presents one cycle of inputs, lets one rising edge pass, then checks at the falling edge.
    task automatic tick(input logic we, input logic [DW-1:0] d, input logic re);
        logic          wa;
        logic          ra;
        logic          e_ovf;
        logic          e_udf;
        logic [DW-1:0] e_d;
        wa    = we && (mc != DEPTH);
        ra    = re && (mc != 0);
        e_ovf = we && (mc == DEPTH);
        e_udf = re && (mc == 0);
        e_d   = '0;
        if (ra) e_d = exp_q.pop_front();
        if (wa) exp_q.push_back(d);
        mc = mc + int'(wa) - int'(ra);
        wr_en = we;
        din   = d;
        rd_en = re;
        @(negedge sys_clk);
        chk("data_cnt", data_cnt, mc);
        chk("full", full, mc == DEPTH);
        chk("empty", empty, mc == 0);
        chk("almost_full", almost_full, mc >= DEPTH - 2);
        chk("almost_empty", almost_empty, mc <= 2);
        chk("overflow", overflow, e_ovf);
        chk("underflow", underflow, e_udf);
`ifdef XCORE_FIFO_FWFT_EN
        chk("dout_vld", dout_vld, mc != 0);
        if (mc != 0) chk("dout_fwft", dout, exp_q[0]);
`else
        chk("dout_vld", dout_vld, ra);
        if (ra) chk("dout", dout, e_d);
`endif
        last_rd = e_d;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cnt"}, data_cnt, 0);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_aempty"}, almost_empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_afull"}, almost_full, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_udf"}, underflow, 0);
        chk({tag, "_vld"}, dout_vld, 0);
`ifndef XCORE_FIFO_FWFT_EN
        chk({tag, "_dout"}, dout, 0);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        mc      = 0;
        last_rd = '0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        din     = '0;
        sys_rst = 1'b1;
        repeat (2) @(negedge sys_clk);
        check_reset_outputs("reset");
        sys_rst = 1'b0;
        @(negedge sys_clk);

        // Fill 0x01..0x10; almost_full appears at count 14
        for (int i = 1; i <= DEPTH; i++) begin
            tick(1'b1, DW'(i), 1'b0);
            if (i == 13) chk("af_at_13", almost_full, 0);
            if (i == 14) chk("af_at_14", almost_full, 1);
        end
        chk("fill_full", full, 1);
        chk("fill_cnt", data_cnt, 16);
        tick(1'b1, 8'h11, 1'b0);
        chk("wr17_ovf", overflow, 1);
        chk("wr17_cnt", data_cnt, 16);
        tick(1'b0, 8'h00, 1'b0);
        chk("ovf_pulse_end", overflow, 0);

        // Drain 16 words in order, then one read too many
        for (int i = 1; i <= DEPTH; i++) begin
`ifdef XCORE_FIFO_FWFT_EN
            chk("fwft_head", dout, DW'(i));
            tick(1'b0, 8'h00, 1'b1);
`else
            tick(1'b0, 8'h00, 1'b1);
            chk("rd_seq", dout, DW'(i));
            chk("rd_seq_vld", dout_vld, 1);
`endif
            if (i == 13) chk("ae_at_3", almost_empty, 0);
            if (i == 14) chk("ae_at_2", almost_empty, 1);
        end
        chk("drain_empty", empty, 1);
        tick(1'b0, 8'h00, 1'b1);
        chk("rd17_udf", underflow, 1);
        chk("rd17_cnt", data_cnt, 0);
        tick(1'b0, 8'h00, 1'b0);
        chk("udf_pulse_end", underflow, 0);

        // Streaming at count 5 across several pointer wraps
        for (int i = 0; i < 5; i++) tick(1'b1, DW'(8'h20 + i), 1'b0);
        for (int i = 0; i < 100; i++) tick(1'b1, DW'(8'h25 + i), 1'b1);
        chk("stream_cnt", data_cnt, 5);
        for (int i = 0; i < 5; i++) tick(1'b0, 8'h00, 1'b1);
`ifndef XCORE_FIFO_FWFT_EN
        chk("stream_last", last_rd, 8'h88);
        chk("stream_last_dout", dout, 8'h88);
`endif

        // Simultaneous write+read at empty, then at full
        tick(1'b1, 8'hA5, 1'b1);
        chk("empty_both_udf", underflow, 1);
        chk("empty_both_cnt", data_cnt, 1);
        tick(1'b0, 8'h00, 1'b1);
`ifndef XCORE_FIFO_FWFT_EN
        chk("empty_both_dout", dout, 8'hA5);
`endif
        for (int i = 0; i < DEPTH; i++) tick(1'b1, DW'(8'h40 + i), 1'b0);
        tick(1'b1, 8'h5A, 1'b1);
        chk("full_both_ovf", overflow, 1);
        chk("full_both_cnt", data_cnt, 15);
        tick(1'b1, 8'h5B, 1'b0);
        chk("refill_cnt", data_cnt, 16);
        for (int i = 0; i < DEPTH; i++) tick(1'b0, 8'h00, 1'b1);

        // Asynchronous reset mid-burst at count 9
        for (int i = 0; i < 9; i++) tick(1'b1, DW'(8'h60 + i), 1'b0);
        chk("pre_rst_cnt", data_cnt, 9);
        #2 sys_rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        wr_en = 1'b0;
        mc = 0;
        exp_q.delete();
        @(negedge sys_clk);
        sys_rst = 1'b0;
        tick(1'b1, 8'h3C, 1'b0);
`ifdef XCORE_FIFO_FWFT_EN
        chk("post_rst_fwft", dout, 8'h3C);
`endif
        tick(1'b0, 8'h00, 1'b1);
`ifndef XCORE_FIFO_FWFT_EN
        chk("post_rst_dout", dout, 8'h3C);
`endif

`ifdef XCORE_FIFO_FWFT_EN
        tick(1'b1, 8'h77, 1'b0);
        chk("fwft_vld", dout_vld, 1);
        chk("fwft_dout", dout, 8'h77);
        tick(1'b0, 8'h00, 1'b1);
        chk("fwft_ack_vld", dout_vld, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
